led_frame_sequencer: RTL and testbench

LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

---
 rtl/led_frame_sequencer_pkg.sv | 31 +++
 rtl/led_frame_sequencer_step_timer.sv | 42 ++++
 rtl/led_frame_sequencer.sv | 150 +++++++++++++++
 tb/tb_led_frame_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_sequencer_pkg.sv
// Shared LED definitions: pattern modes, sequencer states, default step period.
package led_frame_sequencer_pkg;

  // 50 ms at 5 MHz.
  localparam int unsigned LedBaseTicks = 250000;

  typedef enum logic [1:0] {
    ModeCount  = 2'b00,
    ModeWalk   = 2'b01,
    ModeBounce = 2'b10,
    ModeBlink  = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StOffer = 2'b01,
    StWait  = 2'b10
  } led_state_e;

  // First frame of a pattern; blink starts from the captured user pattern.
  function automatic logic [3:0] mode_seed(input led_mode_e mode, input logic [3:0] user_pat);
    logic [3:0] seed;
    case (mode)
      ModeCount: seed = 4'h0;
      ModeBlink: seed = user_pat;
      default:   seed = 4'b0001;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_step_timer.sv
// Step prescaler: counts to BASE_TICKS * 2^rate - 1, then ticks and restarts.
module led_step_timer #(
  parameter int unsigned BASE_TICKS = 250000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       CLOCK_5,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [1:0] rate_i,
  output logic       tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, term;

  // Terminal count for the selected multiplier.
  always_comb begin
    term = (CNT_W'(BASE_TICKS) << rate_i) - CNT_W'(1);
  end

  assign tick_o = enable_i && (cnt_q == term);

  // Clear wins over counting; a tick restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_frame_sequencer.sv
// Generates LED pattern frames at a programmable step rate and offers them
// to the serial driver over a valid/ready handshake.
module led_frame_sequencer
  import led_frame_sequencer_pkg::*;
#(
  parameter int unsigned BASE_TICKS = LedBaseTicks,
  parameter int unsigned CNT_W      = 24
) (
  input  logic        CLOCK_5,
  input  logic        reset,
  input  logic        run,
  input  logic [1:0]  mode,
  input  logic [1:0]  rate_sel,
  input  logic [3:0]  user_pattern,
  input  logic        user_load,
  output logic [3:0]  frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] frame_count,
  output logic        overrun
);

  led_state_e state_q, state_d;
  led_mode_e  mode_q, mode_d, mode_in;
  logic [3:0]  data_q, data_d, user_q, user_d, seed, nxt_data;
  logic [15:0] count_q, count_d;
  logic [1:0]  rate_q, rate_d;
  logic        overrun_q, overrun_d;
  logic        dir_q, dir_d, nxt_dir;  // dir: 0 = shifting left
  logic        tmr_clear, tmr_enable, tick;

  assign mode_in = led_mode_e'(mode);
  assign seed    = mode_seed(mode_in, user_q);

  led_step_timer #(
    .BASE_TICKS(BASE_TICKS),
    .CNT_W     (CNT_W)
  ) u_step_timer (
    .CLOCK_5 (CLOCK_5),
    .reset   (reset),
    .clear_i (tmr_clear),
    .enable_i(tmr_enable),
    .rate_i  (rate_q),
    .tick_o  (tick)
  );

  // Next pattern for a step; a mode change restarts from the new seed.
  always_comb begin
    nxt_data = seed;
    nxt_dir  = 1'b0;
    if (mode_in == mode_q) begin
      case (mode_q)
        ModeCount: nxt_data = data_q + 4'd1;
        ModeWalk:  nxt_data = {data_q[2:0], data_q[3]};
        ModeBounce: begin
          nxt_data = dir_q ? (data_q >> 1) : (data_q << 1);
          nxt_dir  = dir_q;
          if (nxt_data == 4'b1000) begin
            nxt_dir = 1'b1;
          end else if (nxt_data == 4'b0001) begin
            nxt_dir = 1'b0;
          end else if (nxt_data == 4'b0000) begin
            nxt_data = 4'b0001;
            nxt_dir  = 1'b0;
          end
        end
        ModeBlink: nxt_data = (data_q == user_q) ? ~user_q : user_q;
        default:   nxt_data = seed;
      endcase
    end
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    rate_d     = rate_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    user_d     = user_load ? user_pattern : user_q;
    case (state_q)
      StIdle: begin
        tmr_clear = 1'b1;
        if (run) begin
          state_d = StOffer;
          data_d  = seed;
          mode_d  = mode_in;
          dir_d   = 1'b0;
          rate_d  = rate_sel;
        end
      end
      StOffer: begin
        // Free-running here only to flag a step missed by a stalled driver.
        tmr_enable = 1'b1;
        if (tick) overrun_d = 1'b1;
        if (frame_ready) begin
          count_d   = count_q + 16'd1;
          tmr_clear = 1'b1;
          rate_d    = rate_sel;
          state_d   = run ? StWait : StIdle;
        end
      end
      StWait: begin
        tmr_enable = 1'b1;
        if (!run) begin
          state_d = StIdle;
        end else if (tick) begin
          state_d = StOffer;
          data_d  = nxt_data;
          dir_d   = nxt_dir;
          mode_d  = mode_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= ModeCount;
      data_q    <= 4'h0;
      user_q    <= 4'h0;
      count_q   <= 16'h0;
      rate_q    <= 2'b00;
      overrun_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      user_q    <= user_d;
      count_q   <= count_d;
      rate_q    <= rate_d;
      overrun_q <= overrun_d;
      dir_q     <= dir_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = (state_q == StOffer);
  assign frame_count = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer with a short step period.
module tb_led_frame_sequencer;

  localparam int unsigned BaseTicks = 10;

  logic        CLOCK_5 = 1'b0;
  logic        reset, run, user_load, frame_ready, frame_valid, overrun;
  logic [1:0]  mode, rate_sel;
  logic [3:0]  user_pattern, frame_data;
  logic [15:0] frame_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  logic [3:0]  exp_q[$];
  int          xfer_t[$];

  led_frame_sequencer #(
    .BASE_TICKS(BaseTicks),
    .CNT_W     (24)
  ) dut (
    .CLOCK_5     (CLOCK_5),
    .reset       (reset),
    .run         (run),
    .mode        (mode),
    .rate_sel    (rate_sel),
    .user_pattern(user_pattern),
    .user_load   (user_load),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_count (frame_count),
    .overrun     (overrun)
  );

  always #5 CLOCK_5 = ~CLOCK_5;
  always @(posedge CLOCK_5) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_5);
    #1;
  endtask

  // Transfers happen on the next rising edge; compare against the scoreboard.
  always @(negedge CLOCK_5) begin
    if (!reset && frame_valid && frame_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_frame", 32'(frame_valid), 32'd0);
      end else begin
        check("frame", 32'(frame_data), 32'(exp_q.pop_front()));
        xfer_t.push_back(cyc);
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1; run = 1'b0; frame_ready = 1'b0; user_load = 1'b0;
    mode = 2'b00; rate_sel = 2'b00; user_pattern = 4'h0;
    #1;
    check("rst_data", 32'(frame_data), 32'd0);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    step(2);
    reset = 1'b0;
    exp_q.delete();
    xfer_t.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!frame_valid && n < budget) begin
      step(1);
      n++;
    end
    check("wait_valid", 32'(frame_valid), 32'd1);
  endtask

  task automatic check_gaps(input string tag, input int gap);
    for (int i = 1; i < xfer_t.size(); i++) check(tag, 32'(xfer_t[i] - xfer_t[i-1]), 32'(gap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Count mode, x1 rate: 0..F,0 spaced BASE_TICKS+1 cycles.
    apply_reset();
    for (int i = 0; i < 17; i++) exp_q.push_back(4'(i));
    frame_ready = 1'b1; run = 1'b1;
    drain(17 * 11 + 20);
    check("count17", 32'(frame_count), 32'd17);
    check("no_overrun", 32'(overrun), 32'd0);
    check_gaps("gap_x1", 11);
    run = 1'b0;
    step(15);
    check("idle_after_stop", 32'(frame_valid), 32'd0);

    // x2 rate doubles the period.
    apply_reset();
    rate_sel = 2'b01;
    for (int i = 0; i < 3; i++) exp_q.push_back(4'(i));
    frame_ready = 1'b1; run = 1'b1;
    drain(80);
    check_gaps("gap_x2", 21);
    run = 1'b0;
    step(3);

    // Bounce, then switch to walk mid-sequence.
    apply_reset();
    mode = 2'b10;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    frame_ready = 1'b1; run = 1'b1;
    drain(120);
    mode = 2'b01;
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    drain(80);
    run = 1'b0;
    step(3);

    // Stalled driver: frame held, overrun set, no step skipped.
    apply_reset();
    exp_q.push_back(4'h0);
    run = 1'b1;
    wait_valid(5);
    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0) begin
        check("hold_data", 32'(frame_data), 32'd0);
        check("hold_valid", 32'(frame_valid), 32'd1);
      end
      step(1);
    end
    check("overrun_set", 32'(overrun), 32'd1);
    exp_q.push_back(4'h1);
    frame_ready = 1'b1;
    drain(30);
    check("overrun_sticky", 32'(overrun), 32'd1);
    run = 1'b0;
    step(3);

    // Blink with user pattern reloaded while a frame is on offer.
    apply_reset();
    user_pattern = 4'b1010; user_load = 1'b1;
    step(1);
    user_load = 1'b0; mode = 2'b11;
    exp_q = '{4'hA, 4'h5, 4'hA, 4'h5};
    frame_ready = 1'b1; run = 1'b1;
    drain(60);
    frame_ready = 1'b0;
    exp_q.push_back(4'hA);
    wait_valid(20);
    user_pattern = 4'b0011; user_load = 1'b1;
    step(1);
    user_load = 1'b0;
    check("blink_hold", 32'(frame_data), 32'hA);
    step(2);
    check("blink_hold2", 32'(frame_data), 32'hA);
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    frame_ready = 1'b1;
    drain(40);
    run = 1'b0;
    step(3);

    // run dropped during an offer: frame kept until accepted, then idle.
    apply_reset();
    exp_q.push_back(4'h0);
    run = 1'b1;
    wait_valid(5);
    run = 1'b0;
    step(3);
    check("drop_valid_held", 32'(frame_valid), 32'd1);
    check("drop_data_held", 32'(frame_data), 32'd0);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    step(30);
    check("drop_idle", 32'(frame_valid), 32'd0);
    check("drop_count", 32'(frame_count), 32'd1);
    check("drop_q", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-WAIT and mid-OFFER.
    apply_reset();
    mode = 2'b01;
    exp_q.push_back(4'h1);
    frame_ready = 1'b1; run = 1'b1;
    drain(10);
    step(4);
    @(negedge CLOCK_5);
    #1 reset = 1'b1;
    #1;
    check("wait_rst_data", 32'(frame_data), 32'd0);
    check("wait_rst_count", 32'(frame_count), 32'd0);
    check("wait_rst_valid", 32'(frame_valid), 32'd0);
    frame_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    check("rel_valid", 32'(frame_valid), 32'd1);
    check("rel_seed", 32'(frame_data), 32'd1);
    @(negedge CLOCK_5);
    #1 reset = 1'b1;
    #1;
    check("offer_rst_valid", 32'(frame_valid), 32'd0);
    check("offer_rst_data", 32'(frame_data), 32'd0);
    step(2);
    exp_q.push_back(4'h1);
    frame_ready = 1'b1;
    reset = 1'b0;
    step(1);
    check("rel2_valid", 32'(frame_valid), 32'd1);
    drain(5);
    run = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
